// File: rtl/ca_pkg.sv
// Shared types, constants and helpers for the cellular-automaton sweep slice.
package ca_pkg;

  localparam int GRID_N = 8;

  localparam logic [15:0] CA_DEFAULT_RULE = 16'h6634;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] phase_t;

  // Flat bit position of cell (r,c): 8*r+c, which for 3-bit r and c is just {r,c}.
  function automatic logic [5:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
    return {r, c};
  endfunction

endpackage

// File: rtl/ca_cell_rule.sv
// Combinational rule lookup for a single cell of the toroidal grid.
// Gathers the {W,E,N,S} neighbour nibble and indexes the rule table with it.
module ca_cell_rule
  import ca_pkg::*;
(
  input  logic [GRID_N*GRID_N-1:0] i_grid,
  input  logic [2:0]               i_row,
  input  logic [2:0]               i_col,
  input  logic [15:0]              i_rule,
  output logic [3:0]               o_nbr,
  output logic                     o_next
);

  logic [2:0] w_colW;
  logic [2:0] w_colE;
  logic [2:0] w_rowN;
  logic [2:0] w_rowS;

  // Neighbour lookup; 3-bit row/column arithmetic wraps mod 8, giving the torus for free.
  always_comb begin
    w_colW = i_col - 3'd1;
    w_colE = i_col + 3'd1;
    w_rowN = i_row - 3'd1;
    w_rowS = i_row + 3'd1;
    o_nbr  = {i_grid[cell_idx(i_row, w_colW)],
              i_grid[cell_idx(i_row, w_colE)],
              i_grid[cell_idx(w_rowN, i_col)],
              i_grid[cell_idx(w_rowS, i_col)]};
    o_next = i_rule[o_nbr];
  end

endmodule

// File: rtl/ca_sweep_controller.sv
// Owns the 8x8 toroidal CA grid and steps one parity sub-lattice per sweep,
// one active cell per clock, updating the grid in place.
module ca_sweep_controller
  import ca_pkg::*;
#(
  parameter logic [15:0] RULE  = CA_DEFAULT_RULE,
  parameter int          GEN_W = 16
) (
  input  logic             clk,
  input  logic             restart_n,
  input  logic             load,
  input  logic [63:0]      load_data,
  input  logic             butL,
  input  logic             butR,
  input  logic             butU,
  input  logic             butD,
  input  logic             run,
  output logic [63:0]      grid_out,
  output logic             centre,
  output logic             busy,
  output logic             done,
  output logic [1:0]       phase,
  output logic [GEN_W-1:0] gen_count
);

  state_t           r_state;
  state_t           w_stateNext;
  logic [3:0]       r_idx;
  logic [3:0]       w_idxNext;
  phase_t           r_phase;
  phase_t           w_phaseNext;
  logic [63:0]      r_grid;
  logic [GEN_W-1:0] r_gen;

  logic             w_anyBut;
  phase_t           w_butPhase;
  logic [2:0]       w_row;
  logic [2:0]       w_col;
  logic [3:0]       w_unusedNbr;
  logic             w_cellNext;
  logic             w_scanWrite;
  logic             w_genInc;

  // Active cell for this scan step: index bits pick the pair, the phase picks the parity.
  assign w_row = {r_idx[3:2], r_phase[1]};
  assign w_col = {r_idx[1:0], r_phase[0]};

  // The neighbour nibble is only observed inside the rule block; the controller needs the new value.
  ca_cell_rule u_rule (
    .i_grid (r_grid),
    .i_row  (w_row),
    .i_col  (w_col),
    .i_rule (RULE),
    .o_nbr  (w_unusedNbr),
    .o_next (w_cellNext)
  );

  // Start request decode; when several buttons fire together L wins, then R, U, D.
  always_comb begin
    w_anyBut = butL | butR | butU | butD;
    if (butL) begin
      w_butPhase = 2'd0;
    end else if (butR) begin
      w_butPhase = 2'd1;
    end else if (butU) begin
      w_butPhase = 2'd2;
    end else begin
      w_butPhase = 2'd3;
    end
  end

  // Next-state and status decode; a load overrides whatever the sweep would have done.
  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    w_phaseNext = r_phase;
    w_scanWrite = 1'b0;
    w_genInc    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_anyBut) begin
          w_stateNext = SCAN;
          w_idxNext   = 4'd0;
          w_phaseNext = w_butPhase;
        end
      end
      SCAN: begin
        busy        = 1'b1;
        w_scanWrite = 1'b1;
        w_idxNext   = r_idx + 4'd1;
        if (r_idx == 4'd15) begin
          w_stateNext = DONE;
          w_genInc    = 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        if (run) begin
          w_stateNext = SCAN;
          w_idxNext   = 4'd0;
          w_phaseNext = r_phase + 2'd1;
        end else begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
    if (load) begin
      w_stateNext = IDLE;
      w_idxNext   = 4'd0;
      w_phaseNext = r_phase;
      w_scanWrite = 1'b0;
      w_genInc    = 1'b0;
    end
  end

  // Sweep state register: state, scan index and phase.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      r_state <= IDLE;
      r_idx   <= 4'd0;
      r_phase <= 2'd0;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
      r_phase <= w_phaseNext;
    end
  end

  // Grid and generation counter; neighbours of active cells are never active, so no snapshot is needed.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      r_grid <= 64'h0;
      r_gen  <= '0;
    end else if (load) begin
      r_grid <= load_data;
      r_gen  <= '0;
    end else begin
      if (w_scanWrite) begin
        r_grid[cell_idx(w_row, w_col)] <= w_cellNext;
      end
      if (w_genInc) begin
        r_gen <= r_gen + GEN_W'(1);
      end
    end
  end

  assign grid_out  = r_grid;
  assign centre    = r_grid[0];
  assign phase     = r_phase;
  assign gen_count = r_gen;

endmodule

// File: tb/tb_ca_sweep_controller.sv
// Self-checking bench for ca_sweep_controller: a sweep-level model predicts every
// output each cycle, and directed scenarios pin the model with hand-worked values.
module tb_ca_sweep_controller;

  localparam logic [15:0] MODEL_RULE = 16'h6634;

  logic        clk = 1'b0;
  logic        restart_n = 1'b0;
  logic        load = 1'b0;
  logic [63:0] load_data = 64'h0;
  logic        butL = 1'b0;
  logic        butR = 1'b0;
  logic        butU = 1'b0;
  logic        butD = 1'b0;
  logic        run = 1'b0;
  logic [63:0] grid_out;
  logic        centre;
  logic        busy;
  logic        done;
  logic [1:0]  phase;
  logic [15:0] gen_count;

  int vectorsApplied = 0;
  int miscompares = 0;
  int doneSeen = 0;

  logic [63:0] mGrid = 64'h0;
  logic [63:0] mPre = 64'h0;
  logic [63:0] mPost = 64'h0;
  logic [15:0] mGen = 16'h0;
  logic [1:0]  mPhase = 2'd0;
  int          mPos = 0;

  logic [1:0] expPh [5] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

  ca_sweep_controller #(.RULE(16'h6634), .GEN_W(16)) dut (
    .clk       (clk),
    .restart_n (restart_n),
    .load      (load),
    .load_data (load_data),
    .butL      (butL),
    .butR      (butR),
    .butU      (butU),
    .butD      (butD),
    .run       (run),
    .grid_out  (grid_out),
    .centre    (centre),
    .busy      (busy),
    .done      (done),
    .phase     (phase),
    .gen_count (gen_count)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic logic isActive(input int r, input int c, input logic [1:0] ph);
    return ((r % 2) == int'(ph[1])) && ((c % 2) == int'(ph[0]));
  endfunction

  function automatic logic ruleOf(input logic [63:0] g, input int r, input int c);
    logic [15:0] rule;
    int nb;
    rule = MODEL_RULE;
    nb = 8 * int'(g[r*8 + (c+7)%8]) + 4 * int'(g[r*8 + (c+1)%8])
       + 2 * int'(g[((r+7)%8)*8 + c]) + int'(g[((r+1)%8)*8 + c]);
    return rule[nb];
  endfunction

  function automatic logic [63:0] sweepResult(input logic [63:0] g, input logic [1:0] ph);
    logic [63:0] res;
    res = g;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (isActive(r, c, ph)) res[r*8 + c] = ruleOf(g, r, c);
    return res;
  endfunction

  function automatic logic [63:0] blend(input logic [63:0] pre, input logic [63:0] post,
                                        input logic [1:0] ph, input int k);
    logic [63:0] res;
    res = pre;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (isActive(r, c, ph) && ((r/2)*4 + c/2) < k) res[r*8 + c] = post[r*8 + c];
    return res;
  endfunction

  function automatic logic [1:0] startPhase(input logic l, input logic r, input logic u);
    return l ? 2'd0 : (r ? 2'd1 : (u ? 2'd2 : 2'd3));
  endfunction

  // Sweep-level model: mPos 0 idle, 1..16 the sixteen scan cycles, 17 the done cycle.
  always @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      mGrid <= 64'h0; mGen <= 16'h0; mPhase <= 2'd0; mPos <= 0;
    end else if (load) begin
      mGrid <= load_data; mGen <= 16'h0; mPos <= 0;
    end else if (mPos == 0) begin
      if (butL | butR | butU | butD) begin
        mPhase <= startPhase(butL, butR, butU);
        mPre   <= mGrid;
        mPost  <= sweepResult(mGrid, startPhase(butL, butR, butU));
        mPos   <= 1;
      end
    end else if (mPos <= 16) begin
      mPos  <= mPos + 1;
      mGrid <= blend(mPre, mPost, mPhase, mPos);
      if (mPos == 16) mGen <= mGen + 16'd1;
    end else if (run) begin
      mPhase <= mPhase + 2'd1;
      mPre   <= mGrid;
      mPost  <= sweepResult(mGrid, mPhase + 2'd1);
      mPos   <= 1;
    end else begin
      mPos <= 0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, away from the active edge, hold all DUT outputs against the model.
  always @(negedge clk) begin
    checkOutput("grid_out", grid_out, mGrid);
    checkOutput("centre", centre, mGrid[0]);
    checkOutput("busy", busy, (mPos >= 1 && mPos <= 16));
    checkOutput("done", done, (mPos == 17));
    checkOutput("phase", phase, mPhase);
    checkOutput("gen_count", gen_count, mGen);
    if (done) doneSeen <= doneSeen + 1;
  end

  task automatic applyStimulus(input logic iLoad, input logic [63:0] iData, input logic [3:0] iButs);
    @(posedge clk);
    #2;
    load = iLoad;
    load_data = iData;
    {butL, butR, butU, butD} = iButs;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    do begin
      applyStimulus(1'b0, 64'h0, 4'b0000);
      cycles++;
    end while (!done && cycles < 40);
    checkOutput("doneReached", done, 1'b1);
  endtask

  initial begin
    int cnt;
    int donesBefore;

    repeat (3) applyStimulus(1'b0, 64'h0, 4'b0000);
    checkOutput("rst_grid", grid_out, 64'h0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_phase", phase, 2'd0);
    checkOutput("rst_gen", gen_count, 16'd0);
    restart_n = 1'b1;

    $display("[TB] empty grid, phase 0");
    applyStimulus(1'b1, 64'h0, 4'b0000);
    applyStimulus(1'b0, 64'h0, 4'b1000);
    waitDone(cnt);
    checkOutput("t1_latency", cnt, 17);
    checkOutput("t1_grid", grid_out, 64'h0);
    checkOutput("t1_gen", gen_count, 16'd1);
    checkOutput("t1_phase", phase, 2'd0);

    $display("[TB] single east neighbour");
    applyStimulus(1'b1, 64'h2, 4'b0000);
    applyStimulus(1'b0, 64'h0, 4'b1000);
    waitDone(cnt);
    checkOutput("t2_latency", cnt, 17);
    checkOutput("t2_grid", grid_out, 64'h3);
    checkOutput("t2_centre", centre, 1'b1);
    checkOutput("t2_gen", gen_count, 16'd1);

    $display("[TB] toroidal north neighbour");
    applyStimulus(1'b1, 64'h0100_0000_0000_0000, 4'b0000);
    applyStimulus(1'b0, 64'h0, 4'b1000);
    waitDone(cnt);
    checkOutput("t3_grid", grid_out, 64'h0100_0000_0000_0001);

    $display("[TB] button priority and ignore while busy");
    applyStimulus(1'b1, 64'h8421_0F0F_3C3C_1248, 4'b0000);
    applyStimulus(1'b0, 64'h0, 4'b1001);
    donesBefore = doneSeen;
    applyStimulus(1'b0, 64'h0, 4'b0000);
    checkOutput("t4_phase", phase, 2'd0);
    checkOutput("t4_busy", busy, 1'b1);
    repeat (3) applyStimulus(1'b0, 64'h0, 4'b0000);
    applyStimulus(1'b0, 64'h0, 4'b0100);
    waitDone(cnt);
    checkOutput("t4_latency", cnt, 12);
    repeat (20) applyStimulus(1'b0, 64'h0, 4'b0000);
    checkOutput("t4_doneCount", doneSeen - donesBefore, 1);
    checkOutput("t4_gen", gen_count, 16'd1);
    checkOutput("t4_phaseAfter", phase, 2'd0);

    $display("[TB] free run from phase 2");
    applyStimulus(1'b1, 64'hA5C3_0F96_1234_8001, 4'b0000);
    run = 1'b1;
    applyStimulus(1'b0, 64'h0, 4'b0010);
    for (int k = 0; k < 5; k++) begin
      waitDone(cnt);
      checkOutput("t5_latency", cnt, 17);
      checkOutput("t5_phase", phase, expPh[k]);
      checkOutput("t5_gen", gen_count, k + 1);
      checkOutput("t5_busyInDone", busy, 1'b0);
      if (k == 4) run = 1'b0;
    end
    applyStimulus(1'b0, 64'h0, 4'b0000);
    checkOutput("t5_stopBusy", busy, 1'b0);
    checkOutput("t5_stopDone", done, 1'b0);
    repeat (5) applyStimulus(1'b0, 64'h0, 4'b0000);

    $display("[TB] load aborts a sweep");
    applyStimulus(1'b0, 64'h0, 4'b0100);
    repeat (7) applyStimulus(1'b0, 64'h0, 4'b0000);
    donesBefore = doneSeen;
    applyStimulus(1'b1, 64'hFF, 4'b0000);
    applyStimulus(1'b0, 64'h0, 4'b0000);
    checkOutput("t6_grid", grid_out, 64'hFF);
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_gen", gen_count, 16'd0);
    checkOutput("t6_done", done, 1'b0);
    repeat (20) applyStimulus(1'b0, 64'h0, 4'b0000);
    checkOutput("t6_noDone", doneSeen - donesBefore, 0);

    $display("[TB] asynchronous reset mid-sweep");
    applyStimulus(1'b0, 64'h0, 4'b0010);
    waitDone(cnt);
    checkOutput("t7_genBefore", gen_count, 16'd1);
    applyStimulus(1'b0, 64'h0, 4'b0010);
    repeat (5) applyStimulus(1'b0, 64'h0, 4'b0000);
    #1;
    restart_n = 1'b0;
    #1;
    checkOutput("t7_grid", grid_out, 64'h0);
    checkOutput("t7_centre", centre, 1'b0);
    checkOutput("t7_busy", busy, 1'b0);
    checkOutput("t7_done", done, 1'b0);
    checkOutput("t7_phase", phase, 2'd0);
    checkOutput("t7_gen", gen_count, 16'd0);
    repeat (2) applyStimulus(1'b0, 64'h0, 4'b0000);
    restart_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 64'h0, 4'b0000);
    applyStimulus(1'b0, 64'h0, 4'b1000);
    waitDone(cnt);
    checkOutput("t7_latency", cnt, 17);
    checkOutput("t7_genAfter", gen_count, 16'd1);
    repeat (3) applyStimulus(1'b0, 64'h0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
